// File: rtl/tdc_uart_readout.sv
// TDC result reader: captures each result word on the rising edge of iDone, queues it,
// and sends it as an 8N1 UART frame (sync byte + data bytes, MSB byte first).
// Optional: define TDC_RO_CHECKSUM_EN to append an XOR checksum byte to each frame.
module tdc_uart_readout #(
    parameter int          DATA_W       = 24,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                          clk,
    input  logic                          iRst,
    input  logic [DATA_W-1:0]             iData,
    input  logic                          iDone,
    output logic                          oTx,
    output logic                          oBusy,
    output logic                          oOverflow,
    output logic [$clog2(FIFO_DEPTH):0]   oFifoLevel,
    output logic [2:0]                    dbg_state
);

    localparam int NB     = (DATA_W + 7) / 8;
    localparam int WORD_W = NB * 8;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;
`ifdef TDC_RO_CHECKSUM_EN
    localparam int NBYTES = NB + 2;
`else
    localparam int NBYTES = NB + 1;
`endif
    localparam int BW = $clog2(NBYTES + 1);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    // iDone is a strobe with no backpressure: a word is accepted on the first cycle
    // iDone is seen high, and dropped (sticky oOverflow) if the FIFO is full then.
    logic              done_q;
    logic              capture;
    logic              full;
    logic              wr_en;
    logic              pop;
    logic              overflow;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [WORD_W-1:0] word_ext;

    logic [2:0]        state;
    logic              tx;
    logic [CW-1:0]     baud_cnt;
    logic [2:0]        bit_idx;
    logic [BW-1:0]     byte_idx;
    logic [7:0]        sh;
    logic [WORD_W-1:0] word_q;
    logic [7:0]        next_byte;
    logic              baud_end;
    logic              more_bytes;
    logic              has_work;

    assign capture  = iDone & ~done_q;
    assign full     = (level == LW'(FIFO_DEPTH));
    assign wr_en    = capture & ~full;
    assign pop      = (state == LOAD);
    assign word_ext = WORD_W'(mem[rd_ptr]);

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            done_q   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            done_q <= iDone;
            if (capture && full)
                overflow <= 1'b1;
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: the level counter decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= iData;
    end

`ifdef TDC_RO_CHECKSUM_EN
    logic [7:0] csum_next;
    logic [7:0] csum_q;

    always_comb begin
        csum_next = '0;
        for (int i = 0; i < NB; i++)
            csum_next = csum_next ^ word_ext[i*8 +: 8];
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst)
            csum_q <= '0;
        else if (state == LOAD)
            csum_q <= csum_next;
    end

    assign next_byte = (byte_idx == BW'(NB)) ? csum_q : word_q[WORD_W-1 -: 8];
`else
    assign next_byte = word_q[WORD_W-1 -: 8];
`endif

    assign baud_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign more_bytes = (byte_idx != BW'(NBYTES - 1));
    // A word being written this cycle counts as work so LOAD follows the capture edge directly.
    assign has_work   = (level != '0) || wr_en;

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            sh       <= '0;
            word_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (has_work)
                        state <= LOAD;
                end
                LOAD: begin
                    word_q   <= word_ext;
                    sh       <= SYNC_BYTE;
                    byte_idx <= '0;
                    baud_cnt <= '0;
                    tx       <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= sh[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= sh[1];
                            sh      <= sh >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (more_bytes) begin
                            byte_idx <= byte_idx + BW'(1);
                            sh       <= next_byte;
                            word_q   <= word_q << 8;
                            tx       <= 1'b0;
                            state    <= START;
                        end else if (has_work) begin
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oTx        = tx;
    assign oBusy      = (state != IDLE);
    assign oOverflow  = overflow;
    assign oFifoLevel = level;
    assign dbg_state  = state;

endmodule
